// File: rtl/aes_pkg.sv
// rtl/aes_pkg.sv - shared AES constants, key-schedule state encoding and word/byte helpers
package aes_pkg;

    localparam int NR = 10;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_EXPAND = 2'd1,
        ST_EMIT   = 2'd2
    } ks_state_t;

    // Index 0 is unused; round r of the forward schedule consumes RCON[r].
    localparam logic [10:0][7:0] RCON = {8'h36, 8'h1b, 8'h80, 8'h40, 8'h20, 8'h10,
                                         8'h08, 8'h04, 8'h02, 8'h01, 8'h00};

    function automatic logic [7:0] rcon_of(input logic [3:0] r);
        return (r <= 4'd10) ? RCON[r] : 8'h00;
    endfunction

    function automatic logic [31:0] rot_word(input logic [31:0] w);
        return {w[23:0], w[31:24]};
    endfunction

    // Lane helpers: word 0 / byte 0 sit in the most significant position.
    function automatic int word_lo(input int i);
        return 32 * (3 - i);
    endfunction

    function automatic int byte_lo(input int i);
        return 8 * (3 - i);
    endfunction

    function automatic int key_byte_hi(input int i);
        return 127 - 8 * i;
    endfunction

endpackage

// File: rtl/aes_sbox.sv
// rtl/aes_sbox.sv - combinational AES forward S-box
module aes_sbox (
    input  logic [7:0] byte_val,
    output logic [7:0] sub_val
);
    logic [7:0] s;

    always_comb begin
        s = 8'h00;
        case (byte_val)
            8'h00: s = 8'h63; 8'h01: s = 8'h7c; 8'h02: s = 8'h77; 8'h03: s = 8'h7b; 8'h04: s = 8'hf2; 8'h05: s = 8'h6b; 8'h06: s = 8'h6f; 8'h07: s = 8'hc5;
            8'h08: s = 8'h30; 8'h09: s = 8'h01; 8'h0a: s = 8'h67; 8'h0b: s = 8'h2b; 8'h0c: s = 8'hfe; 8'h0d: s = 8'hd7; 8'h0e: s = 8'hab; 8'h0f: s = 8'h76;
            8'h10: s = 8'hca; 8'h11: s = 8'h82; 8'h12: s = 8'hc9; 8'h13: s = 8'h7d; 8'h14: s = 8'hfa; 8'h15: s = 8'h59; 8'h16: s = 8'h47; 8'h17: s = 8'hf0;
            8'h18: s = 8'had; 8'h19: s = 8'hd4; 8'h1a: s = 8'ha2; 8'h1b: s = 8'haf; 8'h1c: s = 8'h9c; 8'h1d: s = 8'ha4; 8'h1e: s = 8'h72; 8'h1f: s = 8'hc0;
            8'h20: s = 8'hb7; 8'h21: s = 8'hfd; 8'h22: s = 8'h93; 8'h23: s = 8'h26; 8'h24: s = 8'h36; 8'h25: s = 8'h3f; 8'h26: s = 8'hf7; 8'h27: s = 8'hcc;
            8'h28: s = 8'h34; 8'h29: s = 8'ha5; 8'h2a: s = 8'he5; 8'h2b: s = 8'hf1; 8'h2c: s = 8'h71; 8'h2d: s = 8'hd8; 8'h2e: s = 8'h31; 8'h2f: s = 8'h15;
            8'h30: s = 8'h04; 8'h31: s = 8'hc7; 8'h32: s = 8'h23; 8'h33: s = 8'hc3; 8'h34: s = 8'h18; 8'h35: s = 8'h96; 8'h36: s = 8'h05; 8'h37: s = 8'h9a;
            8'h38: s = 8'h07; 8'h39: s = 8'h12; 8'h3a: s = 8'h80; 8'h3b: s = 8'he2; 8'h3c: s = 8'heb; 8'h3d: s = 8'h27; 8'h3e: s = 8'hb2; 8'h3f: s = 8'h75;
            8'h40: s = 8'h09; 8'h41: s = 8'h83; 8'h42: s = 8'h2c; 8'h43: s = 8'h1a; 8'h44: s = 8'h1b; 8'h45: s = 8'h6e; 8'h46: s = 8'h5a; 8'h47: s = 8'ha0;
            8'h48: s = 8'h52; 8'h49: s = 8'h3b; 8'h4a: s = 8'hd6; 8'h4b: s = 8'hb3; 8'h4c: s = 8'h29; 8'h4d: s = 8'he3; 8'h4e: s = 8'h2f; 8'h4f: s = 8'h84;
            8'h50: s = 8'h53; 8'h51: s = 8'hd1; 8'h52: s = 8'h00; 8'h53: s = 8'hed; 8'h54: s = 8'h20; 8'h55: s = 8'hfc; 8'h56: s = 8'hb1; 8'h57: s = 8'h5b;
            8'h58: s = 8'h6a; 8'h59: s = 8'hcb; 8'h5a: s = 8'hbe; 8'h5b: s = 8'h39; 8'h5c: s = 8'h4a; 8'h5d: s = 8'h4c; 8'h5e: s = 8'h58; 8'h5f: s = 8'hcf;
            8'h60: s = 8'hd0; 8'h61: s = 8'hef; 8'h62: s = 8'haa; 8'h63: s = 8'hfb; 8'h64: s = 8'h43; 8'h65: s = 8'h4d; 8'h66: s = 8'h33; 8'h67: s = 8'h85;
            8'h68: s = 8'h45; 8'h69: s = 8'hf9; 8'h6a: s = 8'h02; 8'h6b: s = 8'h7f; 8'h6c: s = 8'h50; 8'h6d: s = 8'h3c; 8'h6e: s = 8'h9f; 8'h6f: s = 8'ha8;
            8'h70: s = 8'h51; 8'h71: s = 8'ha3; 8'h72: s = 8'h40; 8'h73: s = 8'h8f; 8'h74: s = 8'h92; 8'h75: s = 8'h9d; 8'h76: s = 8'h38; 8'h77: s = 8'hf5;
            8'h78: s = 8'hbc; 8'h79: s = 8'hb6; 8'h7a: s = 8'hda; 8'h7b: s = 8'h21; 8'h7c: s = 8'h10; 8'h7d: s = 8'hff; 8'h7e: s = 8'hf3; 8'h7f: s = 8'hd2;
            8'h80: s = 8'hcd; 8'h81: s = 8'h0c; 8'h82: s = 8'h13; 8'h83: s = 8'hec; 8'h84: s = 8'h5f; 8'h85: s = 8'h97; 8'h86: s = 8'h44; 8'h87: s = 8'h17;
            8'h88: s = 8'hc4; 8'h89: s = 8'ha7; 8'h8a: s = 8'h7e; 8'h8b: s = 8'h3d; 8'h8c: s = 8'h64; 8'h8d: s = 8'h5d; 8'h8e: s = 8'h19; 8'h8f: s = 8'h73;
            8'h90: s = 8'h60; 8'h91: s = 8'h81; 8'h92: s = 8'h4f; 8'h93: s = 8'hdc; 8'h94: s = 8'h22; 8'h95: s = 8'h2a; 8'h96: s = 8'h90; 8'h97: s = 8'h88;
            8'h98: s = 8'h46; 8'h99: s = 8'hee; 8'h9a: s = 8'hb8; 8'h9b: s = 8'h14; 8'h9c: s = 8'hde; 8'h9d: s = 8'h5e; 8'h9e: s = 8'h0b; 8'h9f: s = 8'hdb;
            8'ha0: s = 8'he0; 8'ha1: s = 8'h32; 8'ha2: s = 8'h3a; 8'ha3: s = 8'h0a; 8'ha4: s = 8'h49; 8'ha5: s = 8'h06; 8'ha6: s = 8'h24; 8'ha7: s = 8'h5c;
            8'ha8: s = 8'hc2; 8'ha9: s = 8'hd3; 8'haa: s = 8'hac; 8'hab: s = 8'h62; 8'hac: s = 8'h91; 8'had: s = 8'h95; 8'hae: s = 8'he4; 8'haf: s = 8'h79;
            8'hb0: s = 8'he7; 8'hb1: s = 8'hc8; 8'hb2: s = 8'h37; 8'hb3: s = 8'h6d; 8'hb4: s = 8'h8d; 8'hb5: s = 8'hd5; 8'hb6: s = 8'h4e; 8'hb7: s = 8'ha9;
            8'hb8: s = 8'h6c; 8'hb9: s = 8'h56; 8'hba: s = 8'hf4; 8'hbb: s = 8'hea; 8'hbc: s = 8'h65; 8'hbd: s = 8'h7a; 8'hbe: s = 8'hae; 8'hbf: s = 8'h08;
            8'hc0: s = 8'hba; 8'hc1: s = 8'h78; 8'hc2: s = 8'h25; 8'hc3: s = 8'h2e; 8'hc4: s = 8'h1c; 8'hc5: s = 8'ha6; 8'hc6: s = 8'hb4; 8'hc7: s = 8'hc6;
            8'hc8: s = 8'he8; 8'hc9: s = 8'hdd; 8'hca: s = 8'h74; 8'hcb: s = 8'h1f; 8'hcc: s = 8'h4b; 8'hcd: s = 8'hbd; 8'hce: s = 8'h8b; 8'hcf: s = 8'h8a;
            8'hd0: s = 8'h70; 8'hd1: s = 8'h3e; 8'hd2: s = 8'hb5; 8'hd3: s = 8'h66; 8'hd4: s = 8'h48; 8'hd5: s = 8'h03; 8'hd6: s = 8'hf6; 8'hd7: s = 8'h0e;
            8'hd8: s = 8'h61; 8'hd9: s = 8'h35; 8'hda: s = 8'h57; 8'hdb: s = 8'hb9; 8'hdc: s = 8'h86; 8'hdd: s = 8'hc1; 8'hde: s = 8'h1d; 8'hdf: s = 8'h9e;
            8'he0: s = 8'he1; 8'he1: s = 8'hf8; 8'he2: s = 8'h98; 8'he3: s = 8'h11; 8'he4: s = 8'h69; 8'he5: s = 8'hd9; 8'he6: s = 8'h8e; 8'he7: s = 8'h94;
            8'he8: s = 8'h9b; 8'he9: s = 8'h1e; 8'hea: s = 8'h87; 8'heb: s = 8'he9; 8'hec: s = 8'hce; 8'hed: s = 8'h55; 8'hee: s = 8'h28; 8'hef: s = 8'hdf;
            8'hf0: s = 8'h8c; 8'hf1: s = 8'ha1; 8'hf2: s = 8'h89; 8'hf3: s = 8'h0d; 8'hf4: s = 8'hbf; 8'hf5: s = 8'he6; 8'hf6: s = 8'h42; 8'hf7: s = 8'h68;
            8'hf8: s = 8'h41; 8'hf9: s = 8'h99; 8'hfa: s = 8'h2d; 8'hfb: s = 8'h0f; 8'hfc: s = 8'hb0; 8'hfd: s = 8'h54; 8'hfe: s = 8'hbb; 8'hff: s = 8'h16;
            default: s = 8'h00;
        endcase
    end

    assign sub_val = s;

endmodule

// File: rtl/aes_inv_key_sched.sv
// rtl/aes_inv_key_sched.sv - AES-128 decrypt-side round-key producer, streams round 10 down to round 0
module aes_inv_key_sched #(
    parameter int NR = 10
) (
    input  logic         sys_clk,
    input  logic         sys_rst,
    input  logic         start,
    input  logic [127:0] key_in,
    output logic         busy,
    output logic         rk_valid,
    input  logic         rk_ready,
    output logic [127:0] rk,
    output logic [3:0]   rk_round,
    output logic         rk_last
);
    import aes_pkg::*;

    if (NR != aes_pkg::NR) begin : g_bad_nr
        $error("aes_inv_key_sched supports only NR=10 (AES-128)");
    end

    localparam logic [3:0] LAST_ROUND = 4'(aes_pkg::NR);

    ks_state_t    state, state_nxt;
    logic [127:0] rk_nxt;
    logic [3:0]   round_nxt;

    logic [31:0] w0, w1, w2, w3;
    logic [31:0] n0, n1, n2, n3;
    logic [31:0] p0, p1, p2, p3;
    logic [31:0] sub_in, sub_rot, sub_out, t_word;

    assign w0 = rk[word_lo(0) +: 32];
    assign w1 = rk[word_lo(1) +: 32];
    assign w2 = rk[word_lo(2) +: 32];
    assign w3 = rk[word_lo(3) +: 32];

    // Stepping backwards first recovers the previous W3 (= W3^W2), which feeds SubWord.
    assign p3 = w3 ^ w2;
    assign p2 = w2 ^ w1;
    assign p1 = w1 ^ w0;

    assign sub_in  = (state == ST_EMIT) ? p3 : w3;
    assign sub_rot = rot_word(sub_in);

    for (genvar i = 0; i < 4; i++) begin : g_sbox
        aes_sbox u_sbox (
            .byte_val (sub_rot[byte_lo(i) +: 8]),
            .sub_val  (sub_out[byte_lo(i) +: 8])
        );
    end

    assign t_word = sub_out ^ {rcon_of(rk_round + 4'd1), 24'h000000};
    assign n0 = w0 ^ t_word;
    assign n1 = w1 ^ n0;
    assign n2 = w2 ^ n1;
    assign n3 = w3 ^ n2;

    assign p0 = w0 ^ sub_out ^ {rcon_of(rk_round), 24'h000000};

    always_comb begin
        state_nxt = state;
        rk_nxt    = rk;
        round_nxt = rk_round;
        case (state)
            ST_IDLE: begin
                if (start) begin
                    rk_nxt    = key_in;
                    round_nxt = 4'd0;
                    state_nxt = ST_EXPAND;
                end
            end
            ST_EXPAND: begin
                rk_nxt    = {n0, n1, n2, n3};
                round_nxt = rk_round + 4'd1;
                if (rk_round == LAST_ROUND - 4'd1) begin
                    state_nxt = ST_EMIT;
                end
            end
            ST_EMIT: begin
                if (rk_ready) begin
                    if (rk_round == 4'd0) begin
                        state_nxt = ST_IDLE;
                    end else begin
                        rk_nxt    = {p0, p1, p2, p3};
                        round_nxt = rk_round - 4'd1;
                    end
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            state    <= ST_IDLE;
            rk       <= '0;
            rk_round <= 4'd0;
        end else begin
            state    <= state_nxt;
            rk       <= rk_nxt;
            rk_round <= round_nxt;
        end
    end

    assign busy     = (state != ST_IDLE);
    assign rk_valid = (state == ST_EMIT);
    assign rk_last  = rk_valid && (rk_round == 4'd0);

endmodule

// File: tb/tb_aes_inv_key_sched.sv
// tb/tb_aes_inv_key_sched.sv - self-checking bench for aes_inv_key_sched with a reverse-order round-key scoreboard
module tb_aes_inv_key_sched;

    logic         sys_clk;
    logic         sys_rst;
    logic         start;
    logic [127:0] key_in;
    logic         busy;
    logic         rk_valid;
    logic         rk_ready;
    logic [127:0] rk;
    logic [3:0]   rk_round;
    logic         rk_last;

    typedef struct packed {
        logic [3:0]   rnd;
        logic [127:0] key;
    } beat_t;

    beat_t        sb_q [$];
    logic [7:0]   m_sbox [0:255];
    logic [127:0] m_rk   [0:10];
    logic [127:0] got_rk [0:10];
    int           n_tests = 0;
    int           n_fail  = 0;

    localparam logic [127:0] FIPS_KEY = 128'h2b7e151628aed2a6abf7158809cf4f3c;

    aes_inv_key_sched #(.NR(10)) dut (
        .sys_clk  (sys_clk),
        .sys_rst  (sys_rst),
        .start    (start),
        .key_in   (key_in),
        .busy     (busy),
        .rk_valid (rk_valid),
        .rk_ready (rk_ready),
        .rk       (rk),
        .rk_round (rk_round),
        .rk_last  (rk_last)
    );

    initial sys_clk = 1'b0;
    always #5 sys_clk = ~sys_clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_tests++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    // Reference S-box built from GF(2^8) inversion plus the affine map.
    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = xtime(x);
        end
        return p;
    endfunction

    function automatic logic [7:0] sbox_ref(input logic [7:0] a);
        logic [7:0] inv;
        logic [7:0] s;
        inv = 8'h01;
        for (int i = 0; i < 254; i++) inv = gmul(inv, a);
        s = inv ^ 8'h63;
        for (int n = 1; n <= 4; n++) s = s ^ ((inv << n) | (inv >> (8 - n)));
        return s;
    endfunction

    function automatic logic [31:0] sub_rot_ref(input logic [31:0] w);
        return {m_sbox[w[23:16]], m_sbox[w[15:8]], m_sbox[w[7:0]], m_sbox[w[31:24]]};
    endfunction

    task automatic model_expand(input logic [127:0] key);
        logic [31:0] w0, w1, w2, w3, t;
        logic [7:0]  rc;
        m_rk[0] = key;
        rc = 8'h01;
        for (int r = 1; r <= 10; r++) begin
            {w0, w1, w2, w3} = m_rk[r-1];
            t  = sub_rot_ref(w3) ^ {rc, 24'h000000};
            w0 = w0 ^ t;
            w1 = w1 ^ w0;
            w2 = w2 ^ w1;
            w3 = w3 ^ w2;
            m_rk[r] = {w0, w1, w2, w3};
            rc = xtime(rc);
        end
    endtask

    task automatic start_key(input logic [127:0] key);
        beat_t b;
        model_expand(key);
        for (int r = 10; r >= 0; r--) begin
            b.rnd = 4'(r);
            b.key = m_rk[r];
            sb_q.push_back(b);
            got_rk[r] = 'x;
        end
        key_in = key;
        start  = 1'b1;
        @(negedge sys_clk);
        start  = 1'b0;
    endtask

    task automatic wait_valid(input bit spam);
        int lat;
        lat = 0;
        while (!rk_valid && lat < 40) begin
            if (spam) begin
                start  = 1'b1;
                key_in = {$urandom(), $urandom(), $urandom(), $urandom()};
            end
            check("busy_expand", 128'(busy), 128'(1));
            @(negedge sys_clk);
            lat++;
        end
        check("first_valid_latency", 128'(lat), 128'(10));
    endtask

    task automatic drain(input int mode, input bit spam, input int stop_at);
        beat_t head;
        bit    rdy;
        int    guard;
        int    stalls;
        guard  = 0;
        stalls = 0;
        while (sb_q.size() > 0 && guard < 400) begin
            head = sb_q[0];
            if (int'(head.rnd) == stop_at) return;
            case (mode)
                0: rdy = 1'b1;
                1: begin
                    if (head.rnd == 4'd7 && stalls < 5) begin
                        rdy = 1'b0;
                        stalls++;
                    end else begin
                        rdy = 1'($urandom_range(0, 1));
                    end
                end
                default: rdy = 1'($urandom_range(0, 1));
            endcase
            rk_ready = rdy;
            if (spam) begin
                start  = 1'b1;
                key_in = {$urandom(), $urandom(), $urandom(), $urandom()};
            end
            check("rk_valid", 128'(rk_valid), 128'(1));
            check("busy_emit", 128'(busy), 128'(1));
            check("rk", rk, head.key);
            check("rk_round", 128'(rk_round), 128'(head.rnd));
            check("rk_last", 128'(rk_last), 128'(head.rnd == 4'd0));
            if (rdy) begin
                got_rk[head.rnd] = rk;
                void'(sb_q.pop_front());
            end
            @(negedge sys_clk);
            guard++;
        end
        check("all_beats_seen", 128'(sb_q.size()), 128'(0));
        start = 1'b0;
        check("busy_after_round0", 128'(busy), 128'(0));
        check("valid_after_round0", 128'(rk_valid), 128'(0));
        check("rk_holds_key", rk, m_rk[0]);
        @(negedge sys_clk);
        check("busy_stays_idle", 128'(busy), 128'(0));
    endtask

    task automatic run_key(input logic [127:0] key, input int mode, input bit spam);
        rk_ready = 1'b1;
        start_key(key);
        wait_valid(spam);
        drain(mode, spam, -1);
    endtask

    task automatic reset_pulse();
        #1;
        sys_rst = 1'b1;
        #1;
        check("rst_busy", 128'(busy), 128'(0));
        check("rst_rk_valid", 128'(rk_valid), 128'(0));
        check("rst_rk", rk, 128'(0));
        check("rst_rk_round", 128'(rk_round), 128'(0));
        check("rst_rk_last", 128'(rk_last), 128'(0));
        sb_q.delete();
        @(negedge sys_clk);
        sys_rst  = 1'b0;
        rk_ready = 1'b1;
        @(negedge sys_clk);
    endtask

    initial begin
        for (int a = 0; a < 256; a++) m_sbox[a] = sbox_ref(8'(a));
        sys_rst  = 1'b1;
        start    = 1'b0;
        rk_ready = 1'b0;
        key_in   = '0;
        @(negedge sys_clk);
        check("reset_busy", 128'(busy), 128'(0));
        check("reset_rk_valid", 128'(rk_valid), 128'(0));
        check("reset_rk", rk, 128'(0));
        check("reset_rk_round", 128'(rk_round), 128'(0));
        check("reset_rk_last", 128'(rk_last), 128'(0));
        sys_rst = 1'b0;
        @(negedge sys_clk);
        check("idle_busy", 128'(busy), 128'(0));

        run_key(FIPS_KEY, 0, 1'b0);
        check("fips_round10", got_rk[10], 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);
        check("fips_round9", got_rk[9], 128'hac7766f319fadc2128d12941575c006e);
        check("fips_round1", got_rk[1], 128'ha0fafe1788542cb123a339392a6c7605);
        check("fips_round0", got_rk[0], FIPS_KEY);

        run_key(FIPS_KEY, 1, 1'b0);
        run_key(128'h000102030405060708090a0b0c0d0e0f, 2, 1'b1);

        start_key(128'h00112233445566778899aabbccddeeff);
        repeat (4) @(negedge sys_clk);
        check("pre_rst_expand_round", 128'(rk_round), 128'(4));
        reset_pulse();

        rk_ready = 1'b1;
        start_key(128'h0f1e2d3c4b5a69788796a5b4c3d2e1f0);
        wait_valid(1'b0);
        drain(0, 1'b0, 6);
        check("pre_rst_emit_round", 128'(rk_round), 128'(6));
        reset_pulse();

        run_key(FIPS_KEY, 0, 1'b0);
        check("post_rst_round10", got_rk[10], 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);

        run_key(128'h0, 0, 1'b0);
        check("zero_key_round10", got_rk[10], 128'hb4ef5bcb3e92e21123e951cf6f8f188e);

        for (int i = 0; i < 200; i++) begin
            run_key({$urandom(), $urandom(), $urandom(), $urandom()}, i % 3, 1'b0);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
